seq_arb: RTL and testbench
==========================

SEQ_ARB -- requirements
Module: seq_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word length in bits, serialized MSB first.
REQ-002 Parameter CNT_WIDTH, default 4: width of per-word hit counter.
REQ-003 Parameter IDX_WIDTH, default 5: width of bit-index output, at least clog2(DATA_WIDTH).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in0_valid / in1_valid  input  1 each  requester 0 / 1 word valid.
REQ-007 in0_ready / in1_ready  output  1 each  requester 0 / 1 word accepted this cycle when valid also high.
REQ-008 in0_data / in1_data  input  DATA_WIDTH each  requester words.
REQ-009 seq_bit  output  1  registered serial bit to detector seq_in.
REQ-010 det_hit  input  1  detector out, high while detector sits in its final-match state.
REQ-011 done  output  1  one-cycle result strobe.
REQ-012 done_id  output  1  requester whose word produced the result.
REQ-013 hit_cnt  output  CNT_WIDTH  hits in the word, saturating.
REQ-014 hit_any  output  1  at least one hit in the word.
REQ-015 first_idx  output  IDX_WIDTH  bit index (0 = MSB) of first hit, 0 when hit_any=0.

Function
REQ-016 States IDLE, SHIFT, DRAIN, DONE; IDLE is the only state with inX_ready possible.
REQ-017 IDLE grant: one valid requester -> granted; both valid -> the one not granted last (round-robin); neither -> stay IDLE.
REQ-018 inX_ready = (state==IDLE) && granted==X, combinational; never both high.
REQ-019 Accept edge E0: latch data into shift register, latch id, clear hit_cnt/hit_any/first_idx, seq_bit<=data[DATA_WIDTH-1], update round-robin pointer, go SHIFT.
REQ-020 Bit k (k=0..DATA_WIDTH-1) drives seq_bit in the cycle after E(k); after the last bit seq_bit<=0 and stays 0 outside SHIFT.
REQ-021 Detector consumes bit k at E(k+1); controller samples det_hit for bit k at E(k+2); det_hit outside these DATA_WIDTH sample edges is ignored.
REQ-022 SHIFT exits to DRAIN at E(DATA_WIDTH); DRAIN takes the last sample at E(DATA_WIDTH+1) and goes DONE; DONE goes IDLE at next edge.
REQ-023 done high exactly one cycle, DATA_WIDTH+1 cycles after accept edge; done_id/hit_cnt/hit_any/first_idx valid then and held until next accept.
REQ-024 Each sampled hit: hit_cnt+1, holding at 2^CNT_WIDTH-1; first hit also sets hit_any=1, first_idx=k.
REQ-025 At least 3 zero bits separate consecutive words (DRAIN, DONE, accept cycle), returning the detector to idle; hits never span words.
REQ-026 Minimum accept-to-accept spacing DATA_WIDTH+3 cycles with valid held.
REQ-027 Arbitration is decided only in IDLE; valid changes in other states have no effect.

Reset
REQ-028 rst_n low: state IDLE, seq_bit=0, done=0, done_id=0, hit_cnt=0, hit_any=0, first_idx=0, round-robin pointer set so requester 0 wins first tie.
REQ-029 Reset mid-word discards the word: no done, shift register contents irrelevant; operation resumes from IDLE on rst_n release.

Verification
REQ-030 in0 word 16'hAD80 -> seq_bit 1,0,1,0,1,1,0,1,1,0... ; done 17 cycles after accept, done_id=0, hit_cnt=1, hit_any=1, first_idx=8.
REQ-031 in1 word 16'hFFFF -> done_id=1, hit_cnt=0, hit_any=0, first_idx=0.
REQ-032 in0 and in1 valid from reset, three words held back-to-back -> grant order 0,1,0; accepts 19 cycles apart; ready never both high.
REQ-033 in0 16'h000A then 16'hDB00 (pattern split across words) -> both results hit_cnt=0; 16'h56C0 -> hit_cnt=1, first_idx=9.
REQ-034 DATA_WIDTH=32, CNT_WIDTH=1, word 32'hADAD8000 -> overlapping hits at k=8 and k=16; hit_cnt=1 (saturated), first_idx=8.
REQ-035 rst_n pulsed low while bit 5 of a word is on seq_bit -> seq_bit=0 immediately, no done; next word 16'hAD80 gives hit_cnt=1, first_idx=8.

Source files
------------

// File: rtl/seq_arb_if.sv
// Handshake and detector-side signals of the two-requester serializing arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface seq_arb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int IDX_WIDTH  = 5
);
  logic                  in0_valid;
  logic                  in0_ready;
  logic [DATA_WIDTH-1:0] in0_data;
  logic                  in1_valid;
  logic                  in1_ready;
  logic [DATA_WIDTH-1:0] in1_data;
  logic                  seq_bit;
  logic                  det_hit;
  logic                  done;
  logic                  done_id;
  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic                  hit_any;
  logic [IDX_WIDTH-1:0]  first_idx;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, det_hit,
    output in0_ready, in1_ready, seq_bit, done, done_id, hit_cnt, hit_any, first_idx
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, det_hit,
    input  in0_ready, in1_ready, seq_bit, done, done_id, hit_cnt, hit_any, first_idx
  );
endinterface

// File: rtl/seq_arb.sv
// Round-robin arbiter that serializes one requester word MSB first into an external
// sequence detector and reports how many times, and first where, the detector matched.
module seq_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int IDX_WIDTH  = 5
) (
  input logic   clk,
  input logic   rst_n,
  seq_arb_if.slave bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  granted;
  logic                  accept;
  logic                  sample_en;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] data_sel;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BCW-1:0]        bit_cnt;
  logic [IDX_WIDTH-1:0]  samp_idx;

  logic                  seq_bit_q;
  logic                  done_q;
  logic                  done_id_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic                  hit_any_q;
  logic [IDX_WIDTH-1:0]  first_idx_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    granted = ~last_grant;
    if (bus.in0_valid && !bus.in1_valid) begin
      granted = 1'b0;
    end else if (bus.in1_valid && !bus.in0_valid) begin
      granted = 1'b1;
    end
    accept    = (state == IDLE) && (granted ? bus.in1_valid : bus.in0_valid);
    data_sel  = granted ? bus.in1_data : bus.in0_data;
    // det_hit for bit k is valid two edges after bit k was launched.
    sample_en = ((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN);
    last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
  end

  assign bus.in0_ready = (state == IDLE) && !granted;
  assign bus.in1_ready = (state == IDLE) &&  granted;
  assign bus.seq_bit   = seq_bit_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.hit_any   = hit_any_q;
  assign bus.first_idx = first_idx_q;

  // NOTE: the word buffer is pure datapath; it is always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= data_sel << 1;
    end else if (state == SHIFT) begin
      shift_reg <= shift_reg << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      bit_cnt     <= '0;
      samp_idx    <= '0;
      seq_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      hit_cnt_q   <= '0;
      hit_any_q   <= 1'b0;
      first_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      done_q <= 1'b0;

      if (sample_en) begin
        samp_idx <= samp_idx + 1'b1;
        if (bus.det_hit) begin
          if (hit_cnt_q != '1) begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
          end
          if (!hit_any_q) begin
            hit_any_q   <= 1'b1;
            first_idx_q <= samp_idx;
          end
        end
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            state       <= SHIFT;
            last_grant  <= granted;
            done_id_q   <= granted;
            hit_cnt_q   <= '0;
            hit_any_q   <= 1'b0;
            first_idx_q <= '0;
            bit_cnt     <= '0;
            samp_idx    <= '0;
            seq_bit_q   <= data_sel[DATA_WIDTH-1];
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            seq_bit_q <= 1'b0;
            state     <= DRAIN;
          end else begin
            seq_bit_q <= shift_reg[DATA_WIDTH-1];
          end
        end
        DRAIN: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arb.sv
// Directed bench for seq_arb: a 9-bit overlapping detector for 101011011 closes the
// loop; a 16-bit instance covers arbitration and results, a 32-bit one saturation.
module tb_seq_arb;

  localparam logic [8:0] DET_PAT = 9'b101011011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_arb_if #(.DATA_WIDTH(16), .CNT_WIDTH(4), .IDX_WIDTH(5)) bus16 ();
  seq_arb    #(.DATA_WIDTH(16), .CNT_WIDTH(4), .IDX_WIDTH(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  seq_arb_if #(.DATA_WIDTH(32), .CNT_WIDTH(1), .IDX_WIDTH(5)) bus32 ();
  seq_arb    #(.DATA_WIDTH(32), .CNT_WIDTH(1), .IDX_WIDTH(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // Detector models: the last 9 consumed bits compared against the pattern.
  logic [8:0] hist16, hist32;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist16 <= '0;
      hist32 <= '0;
    end else begin
      hist16 <= {hist16[7:0], bus16.seq_bit};
      hist32 <= {hist32[7:0], bus32.seq_bit};
    end
  end
  assign bus16.det_hit = (hist16 == DET_PAT);
  assign bus32.det_hit = (hist32 == DET_PAT);

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] data;
    logic        exp_id;
    logic [3:0]  exp_cnt;
    logic        exp_any;
    logic [4:0]  exp_idx;
  } vec_t;

  vec_t vecs[7];

  // Offer one word on requester sel, capture its serial bits and the done latency.
  task automatic send16(input logic sel, input logic [15:0] data, output logic ok,
                        output int lat, output logic [15:0] bits, output logic tail);
    ok   = 1'b0;
    lat  = -1;
    bits = '0;
    tail = 1'b1;
    @(negedge clk);
    if (sel) begin
      bus16.in1_data  = data;
      bus16.in1_valid = 1'b1;
    end else begin
      bus16.in0_data  = data;
      bus16.in0_valid = 1'b1;
    end
    #1;
    for (int w = 0; w < 50; w++) begin
      if (sel ? bus16.in1_ready : bus16.in0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      bus16.in0_valid = 1'b0;
      bus16.in1_valid = 1'b0;
      for (int c = 0; c <= 40; c++) begin
        if (c < 16) bits[15-c] = bus16.seq_bit;
        if (c == 16) tail = bus16.seq_bit;
        if (bus16.done) begin
          lat = c;
          break;
        end
        @(negedge clk);
      end
    end else begin
      bus16.in0_valid = 1'b0;
      bus16.in1_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok, tail, both_hi, seen;
    int          lat, n_acc;
    int          acc_cyc[3];
    logic        acc_id[3];
    logic [15:0] bits;

    vecs[0] = '{1'b0, 16'hAD80, 1'b0, 4'd1, 1'b1, 5'd8};
    vecs[1] = '{1'b1, 16'hFFFF, 1'b1, 4'd0, 1'b0, 5'd0};
    vecs[2] = '{1'b0, 16'h000A, 1'b0, 4'd0, 1'b0, 5'd0};
    vecs[3] = '{1'b0, 16'hDB00, 1'b0, 4'd0, 1'b0, 5'd0};
    vecs[4] = '{1'b0, 16'h56C0, 1'b0, 4'd1, 1'b1, 5'd9};
    vecs[5] = '{1'b1, 16'h015B, 1'b1, 4'd1, 1'b1, 5'd15};
    vecs[6] = '{1'b1, 16'hAD80, 1'b1, 4'd1, 1'b1, 5'd8};

    bus16.in0_valid = 1'b0; bus16.in1_valid = 1'b0;
    bus16.in0_data  = '0;   bus16.in1_data  = '0;
    bus32.in0_valid = 1'b0; bus32.in1_valid = 1'b0;
    bus32.in0_data  = '0;   bus32.in1_data  = '0;

    // Reset state
    #12;
    check("rst_seq_bit",   bus16.seq_bit,   0);
    check("rst_done",      bus16.done,      0);
    check("rst_done_id",   bus16.done_id,   0);
    check("rst_hit_cnt",   bus16.hit_cnt,   0);
    check("rst_hit_any",   bus16.hit_any,   0);
    check("rst_first_idx", bus16.first_idx, 0);
    check("rst_in0_ready", bus16.in0_ready, 1);
    check("rst_in1_ready", bus16.in1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters valid from reset: grants alternate starting with requester 0
    bus16.in0_data  = 16'h1234;
    bus16.in1_data  = 16'h5678;
    bus16.in0_valid = 1'b1;
    bus16.in1_valid = 1'b1;
    n_acc   = 0;
    both_hi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = 0;
      acc_id[i]  = 1'b0;
    end
    for (int c = 0; c < 100 && n_acc < 3; c++) begin
      #1;
      if (bus16.in0_ready && bus16.in1_ready) begin
        both_hi = 1'b1;
      end else if (bus16.in0_ready || bus16.in1_ready) begin
        acc_cyc[n_acc] = c;
        acc_id[n_acc]  = bus16.in1_ready;
        n_acc++;
      end
      @(negedge clk);
    end
    bus16.in0_valid = 1'b0;
    bus16.in1_valid = 1'b0;
    check("rr_accepts",  n_acc,   3);
    check("rr_both_rdy", both_hi, 0);
    check("rr_grant0",   acc_id[0], 0);
    check("rr_grant1",   acc_id[1], 1);
    check("rr_grant2",   acc_id[2], 0);
    check("rr_space01",  acc_cyc[1] - acc_cyc[0], 19);
    check("rr_space12",  acc_cyc[2] - acc_cyc[1], 19);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus16.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rr_last_done",    seen,          1);
    check("rr_last_done_id", bus16.done_id, 0);

    // Table-driven words
    for (int i = 0; i < 7; i++) begin
      send16(vecs[i].sel, vecs[i].data, ok, lat, bits, tail);
      check($sformatf("v%0d_accept", i),    ok,              1);
      check($sformatf("v%0d_latency", i),   lat,             17);
      check($sformatf("v%0d_bits", i),      bits,            vecs[i].data);
      check($sformatf("v%0d_tail", i),      tail,            0);
      check($sformatf("v%0d_done_id", i),   bus16.done_id,   vecs[i].exp_id);
      check($sformatf("v%0d_hit_cnt", i),   bus16.hit_cnt,   vecs[i].exp_cnt);
      check($sformatf("v%0d_hit_any", i),   bus16.hit_any,   vecs[i].exp_any);
      check($sformatf("v%0d_first_idx", i), bus16.first_idx, vecs[i].exp_idx);
    end

    // Done is a single-cycle strobe
    @(negedge clk);
    check("done_one_cycle", bus16.done, 0);

    // Reset while bit 5 of a word is on seq_bit
    @(negedge clk);
    bus16.in0_data  = 16'hFC00;
    bus16.in0_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int w = 0; w < 50; w++) begin
      if (bus16.in0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("mid_accept", ok, 1);
    @(posedge clk);
    @(negedge clk);
    bus16.in0_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_bit5", bus16.seq_bit, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_seq_bit", bus16.seq_bit, 0);
    check("mid_rst_done",    bus16.done,    0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus16.done) seen = 1'b1;
    end
    check("mid_no_done", seen, 0);
    send16(1'b0, 16'hAD80, ok, lat, bits, tail);
    check("post_accept",    ok,              1);
    check("post_latency",   lat,             17);
    check("post_done_id",   bus16.done_id,   0);
    check("post_hit_cnt",   bus16.hit_cnt,   1);
    check("post_first_idx", bus16.first_idx, 8);
    repeat (3) @(negedge clk);
    check("hold_hit_cnt",   bus16.hit_cnt,   1);
    check("hold_first_idx", bus16.first_idx, 8);

    // 32-bit word, two hits into a 1-bit saturating counter
    @(negedge clk);
    bus32.in0_data  = 32'hADAD8000;
    bus32.in0_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int w = 0; w < 50; w++) begin
      if (bus32.in0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("w32_accept", ok, 1);
    @(posedge clk);
    @(negedge clk);
    bus32.in0_valid = 1'b0;
    lat = -1;
    for (int c = 0; c <= 60; c++) begin
      if (bus32.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check("w32_latency",   lat,             33);
    check("w32_done_id",   bus32.done_id,   0);
    check("w32_hit_cnt",   bus32.hit_cnt,   1);
    check("w32_hit_any",   bus32.hit_any,   1);
    check("w32_first_idx", bus32.first_idx, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
